// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and byte width for the UART transmit arbiter
package uart_pkg;
    localparam int UART_BYTE_W = 8;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN  = 2'b01,
        SEND = 2'b10
    } arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search returning a one-hot pick starting at a pointer
module rr_pick
    import uart_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_pick,
    output logic          o_found
);
    logic [PW-1:0] w_idx;
    // Scan requests from the pointer upward, wrapping modulo N; first hit wins
    always_comb begin
        o_pick  = '0;
        o_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = PW'((int'(i_ptr) + k) % N);
            if (!o_found && i_req[w_idx]) begin
                o_pick[w_idx] = 1'b1;
                o_found       = 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: frame-level round-robin sharing of one UART transmitter; UART_ARB_TIMEOUT_EN adds stalled-owner revocation
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 50000
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [NREQ-1:0]             i_req_valid,
    input  logic [NREQ*UART_BYTE_W-1:0] i_req_data,
    input  logic [NREQ-1:0]             i_req_last,
    output logic [NREQ-1:0]             o_req_ready,
    output logic                        o_tx_valid,
    output logic [UART_BYTE_W-1:0]      o_tx_data,
    input  logic                        i_tx_ready,
    output logic [NREQ-1:0]             o_grant,
    output logic                        o_busy,
    output logic                        o_timeout_pulse
);
    localparam int PW = $clog2(NREQ);

    arb_state_t             r_state;
    logic [NREQ-1:0]        r_grant;
    logic [PW-1:0]          r_owner;
    logic [PW-1:0]          r_ptr;
    logic [UART_BYTE_W-1:0] r_data;
    logic                   r_last;
    logic                   r_tx_valid;
    logic                   r_busy;
    logic [NREQ-1:0]        w_pick;
    logic                   w_found;
    logic [PW-1:0]          w_pick_idx;
    logic [PW-1:0]          w_next;

    rr_pick #(.N(NREQ), .PW(PW)) u_pick (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_pick  (w_pick),
        .o_found (w_found)
    );

    // Binary index of the one-hot pick, kept so the owner can address its data slice
    always_comb begin
        w_pick_idx = '0;
        for (int k = 0; k < NREQ; k++)
            if (w_pick[k]) w_pick_idx = PW'(k);
    end

    assign w_next = (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
    logic [31:0] r_cnt;
    logic        r_timeout_pulse;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^32'(TIMEOUT);
`endif

    // Arbitration FSM: grant in IDLE, accept one byte in OWN, hand it off in SEND
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_owner    <= '0;
            r_ptr      <= '0;
            r_data     <= '0;
            r_last     <= 1'b0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            r_cnt           <= '0;
            r_timeout_pulse <= 1'b0;
`endif
        end else begin
`ifdef UART_ARB_TIMEOUT_EN
            r_timeout_pulse <= 1'b0;
`endif
            case (r_state)
                IDLE: if (w_found) begin
                    r_grant <= w_pick;
                    r_owner <= w_pick_idx;
                    r_busy  <= 1'b1;
                    r_state <= OWN;
                end
                OWN: if (i_req_valid[r_owner]) begin
                    r_data     <= i_req_data[int'(r_owner)*UART_BYTE_W +: UART_BYTE_W];
                    r_last     <= i_req_last[r_owner];
                    r_tx_valid <= 1'b1;
                    r_state    <= SEND;
`ifdef UART_ARB_TIMEOUT_EN
                    r_cnt      <= '0;
                end else if (r_cnt == 32'(TIMEOUT) - 32'd1) begin
                    r_cnt           <= '0;
                    r_timeout_pulse <= 1'b1;
                    r_grant         <= '0;
                    r_busy          <= 1'b0;
                    r_ptr           <= w_next;
                    r_state         <= IDLE;
                end else begin
                    r_cnt <= r_cnt + 32'd1;
`endif
                end
                SEND: if (i_tx_ready) begin
                    r_tx_valid <= 1'b0;
                    if (r_last) begin
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_ptr   <= w_next;
                        r_state <= IDLE;
                    end else begin
                        r_state <= OWN;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_req_ready = (r_state == OWN) ? (r_grant & i_req_valid) : '0;
    assign o_tx_valid  = r_tx_valid;
    assign o_tx_data   = r_data;
    assign o_grant     = r_grant;
    assign o_busy      = r_busy;
`ifdef UART_ARB_TIMEOUT_EN
    assign o_timeout_pulse = r_timeout_pulse;
`else
    assign o_timeout_pulse = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter (table of frames plus hand-written corner sequences)
module tb_uart_tx_arbiter;
    import uart_pkg::*;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid, req_last, req_ready, grant;
    logic [N*8-1:0] req_data;
    logic           tx_valid, tx_ready, busy, tpulse;
    logic [7:0]     tx_data;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NREQ(N), .TIMEOUT(10)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_req_valid     (req_valid),
        .i_req_data      (req_data),
        .i_req_last      (req_last),
        .o_req_ready     (req_ready),
        .o_tx_valid      (tx_valid),
        .o_tx_data       (tx_data),
        .i_tx_ready      (tx_ready),
        .o_grant         (grant),
        .o_busy          (busy),
        .o_timeout_pulse (tpulse)
    );

    typedef struct { int s; logic [7:0] d; logic l; } beat_t;
    typedef struct { logic [7:0] d; logic [N-1:0] g; } exp_t;
    typedef struct { int s; int n; logic [7:0] b; logic [N-1:0] g; } vec_t;

    beat_t src_q[$];
    exp_t  sb[$];
    vec_t  vt[5];
    logic  txr_want = 1'b1;
    int    n_vec = 0, n_err = 0, cyc = 0, n_rdy = 0, acc0_cyc = -1, pulse_cyc = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic int head(input int s);
        for (int k = 0; k < src_q.size(); k++)
            if (src_q[k].s == s) return k;
        return -1;
    endfunction

    task automatic load(input int s, input int n, input logic [7:0] b, input logic [N-1:0] g);
        for (int k = 0; k < n; k++) begin
            src_q.push_back('{s, b + 8'(k), k == n - 1});
            sb.push_back('{b + 8'(k), g});
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_tx_valid"}, tx_valid, 0);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_timeout_pulse"}, tpulse, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        src_q.delete();
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while ((sb.size() != 0 || busy) && c < budget) begin
            tick();
            c++;
        end
        check("drain_done", 32'(sb.size() == 0 && !busy), 1);
    endtask

    task automatic wait_tx_valid(input string name);
        int c = 0;
        while (!tx_valid && c < 10) begin
            tick();
            c++;
        end
        check(name, tx_valid, 1);
    endtask

    // Requester and serializer model: drive heads of the source queues, then record handshakes
    initial begin
        int    k;
        exp_t  e;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            req_valid = '0;
            req_data  = '0;
            req_last  = '0;
            tx_ready  = txr_want;
            for (int i = 0; i < N; i++) begin
                k = head(i);
                if (k >= 0) begin
                    req_valid[i]       = 1'b1;
                    req_data[i*8 +: 8] = src_q[k].d;
                    req_last[i]        = src_q[k].l;
                end
            end
            #1;
            if (tpulse) pulse_cyc = cyc;
            if (req_ready != '0) begin
                n_rdy++;
                check("ready_onehot", 32'($onehot(req_ready)), 1);
                for (int i = 0; i < N; i++) begin
                    if (req_ready[i]) begin
                        if (i == 0) acc0_cyc = cyc;
                        k = head(i);
                        if (k >= 0) src_q.delete(k);
                    end
                end
            end
            if (tx_valid && tx_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL tx_unexpected: got %02h, want no byte", tx_data);
                end else begin
                    e = sb.pop_front();
                    check("tx_data", tx_data, e.d);
                    check("tx_grant", grant, e.g);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got %0d cycles", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int r0;
        vt[0] = '{0, 2, 8'h68, 4'b0001};
        vt[1] = '{3, 1, 8'hA0, 4'b1000};
        vt[2] = '{2, 4, 8'h10, 4'b0100};
        vt[3] = '{1, 3, 8'hC3, 4'b0010};
        vt[4] = '{0, 1, 8'hFF, 4'b0001};
        rst_n = 1'b0;
        tick();
        tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            r0 = n_rdy;
            load(vt[i].s, vt[i].n, vt[i].b, vt[i].g);
            drain(60);
            check("frame_ready_pulses", n_rdy - r0, vt[i].n);
            check("frame_grant_idle", grant, 0);
        end
        do_reset();
        load(1, 1, 8'hB1, 4'b0010);
        load(2, 1, 8'hB2, 4'b0100);
        load(1, 1, 8'hB3, 4'b0010);
        drain(60);
        load(0, 3, 8'hC0, 4'b0001);
        tick();
        load(3, 1, 8'hD0, 4'b1000);
        drain(60);
        txr_want = 1'b0;
        load(0, 2, 8'h55, 4'b0001);
        wait_tx_valid("bp_tx_valid_seen");
        r0 = n_rdy;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_tx_valid", tx_valid, 1);
            check("bp_tx_data", tx_data, 8'h55);
        end
        check("bp_no_ready", n_rdy - r0, 0);
        txr_want = 1'b1;
        drain(60);
        do_reset();
        acc0_cyc  = -1;
        pulse_cyc = -1;
        src_q.push_back('{0, 8'h31, 1'b0});
        src_q.push_back('{1, 8'h41, 1'b1});
        sb.push_back('{8'h31, 4'b0001});
`ifdef UART_ARB_TIMEOUT_EN
        sb.push_back('{8'h41, 4'b0010});
        repeat (25) tick();
        check("to_pulse_seen", 32'(pulse_cyc > 0), 1);
        check("to_pulse_delay", 32'(pulse_cyc - acc0_cyc >= 10 && pulse_cyc - acc0_cyc <= 13), 1);
        drain(60);
        check("to_grant_idle", grant, 0);
`else
        repeat (25) tick();
        check("stall_grant_kept", grant, 4'b0001);
        check("stall_busy", busy, 1);
        check("stall_no_pulse", 32'(pulse_cyc == -1), 1);
        src_q.push_back('{0, 8'h32, 1'b1});
        sb.push_back('{8'h32, 4'b0001});
        sb.push_back('{8'h41, 4'b0010});
        drain(60);
`endif
        do_reset();
        load(1, 1, 8'hE1, 4'b0010);
        drain(60);
        txr_want = 1'b0;
        load(2, 3, 8'hE0, 4'b0100);
        wait_tx_valid("mid_tx_valid_seen");
        rst_n = 1'b0;
        #1;
        check_zero("mid_reset");
        src_q.delete();
        sb.delete();
        txr_want = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        load(0, 1, 8'hF0, 4'b0001);
        load(3, 1, 8'hF3, 4'b1000);
        drain(60);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
